// File: rtl/jkff_bank_ctrl_pkg.sv
// Shared definitions for the JK flip-flop bank controller.
//   - opcode values carried on Cmd_Op
//   - controller state encoding
//   - default run-length field width
//   - small opcode classification helpers
package jkff_ctrl_pkg;

  localparam int unsigned DEF_CNT_W = 8;

  // Opcodes
  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_CLEAR  = 3'd1;
  localparam logic [2:0] OP_PRESET = 3'd2;
  localparam logic [2:0] OP_LOAD   = 3'd3;
  localparam logic [2:0] OP_UP     = 3'd4;
  localparam logic [2:0] OP_DOWN   = 3'd5;
  localparam logic [2:0] OP_TOGGLE = 3'd6;
  localparam logic [2:0] OP_HOLD   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PULSE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Ops that drive async set/clear and are verified against Q afterwards.
  function automatic logic is_load_op(input logic [2:0] op);
    return (op == OP_CLEAR) || (op == OP_PRESET) || (op == OP_LOAD);
  endfunction

  // Ops whose run length comes from Cmd_Cnt (zero means finish at once).
  function automatic logic is_counted_op(input logic [2:0] op);
    return (op == OP_UP) || (op == OP_DOWN) || (op == OP_HOLD);
  endfunction

endpackage

// File: rtl/jkff_bank_ctrl_if.sv
// Command channel between the lab command source and the bank controller.
//   Cmd_Valid  source -> ctrl  command present
//   Cmd_Ready  ctrl -> source  controller idle, command can be accepted
//   Cmd_Op     source -> ctrl  opcode (see jkff_ctrl_pkg)
//   Cmd_Data   source -> ctrl  load value or toggle mask
//   Cmd_Cnt    source -> ctrl  run length in clocks
// master: the command source; slave: the controller.
interface jkff_bank_ctrl_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = jkff_ctrl_pkg::DEF_CNT_W
);

  logic             Cmd_Valid;
  logic             Cmd_Ready;
  logic [2:0]       Cmd_Op;
  logic [WIDTH-1:0] Cmd_Data;
  logic [CNT_W-1:0] Cmd_Cnt;

  modport master (
    output Cmd_Valid,
    output Cmd_Op,
    output Cmd_Data,
    output Cmd_Cnt,
    input  Cmd_Ready
  );

  modport slave (
    input  Cmd_Valid,
    input  Cmd_Op,
    input  Cmd_Data,
    input  Cmd_Cnt,
    output Cmd_Ready
  );

endinterface

// File: rtl/jkff_bank_ctrl_next.sv
// jk_next_logic: combinational J/K generator for a bank of JK flip-flops.
//   op    in  3      opcode; only UP, DOWN and TOGGLE produce non-zero J/K
//   q     in  WIDTH  current Q of the bank
//   mask  in  WIDTH  toggle mask for TOGGLE
//   j, k  out WIDTH  J and K inputs of the bank (always equal: T-style use)
// UP toggles bit i when all lower bits are 1, DOWN when all lower bits are 0,
// which gives a synchronous binary counter of any width.
module jk_next_logic
  import jkff_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic [WIDTH-1:0] t;

  // The MSB never feeds a higher stage; wrap-around is implicit.
  logic unused_msb;
  assign unused_msb = q[WIDTH-1];

  // Prefix-AND chains over Q and ~Q.
  always_comb begin
    up_t    = '0;
    dn_t    = '0;
    up_t[0] = 1'b1;
    dn_t[0] = 1'b1;
    for (int i = 1; i < int'(WIDTH); i++) begin
      up_t[i] = up_t[i-1] & q[i-1];
      dn_t[i] = dn_t[i-1] & ~q[i-1];
    end
  end

  always_comb begin
    t = '0;
    case (op)
      OP_UP:     t = up_t;
      OP_DOWN:   t = dn_t;
      OP_TOGGLE: t = mask;
      default:   t = '0;
    endcase
  end

  assign j = t;
  assign k = t;

endmodule

// File: rtl/jkff_bank_ctrl.sv
// jkff_bank_ctrl: command-driven sequencer for a bank of WIDTH 74HC112-style
// JK flip-flops sharing Clk with this controller.
//   Clk      in   rising-edge clock (also clocks the bank)
//   R_N      in   asynchronous active-low reset; forces FF_R high while low
//   cmd      slave side of the command channel (valid/ready, op, data, cnt)
//   FF_Q     in   Q feedback from the bank
//   FF_J/K   out  J/K to the bank, non-zero only while running
//   FF_S/R   out  async set/clear to the bank (active-high), pulsed
//   Busy     out  controller not idle
//   Done     out  one-cycle completion pulse
//   Err      out  one-cycle pulse with Done when a load-type op failed verify
// Load-type ops (CLEAR/PRESET/LOAD) pulse S/R for PULSE_CYC cycles, let the
// bank settle one cycle, then compare Q. Run ops (UP/DOWN/TOGGLE/HOLD) drive
// J/K for exactly N bank clocks.
module jkff_bank_ctrl
  import jkff_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic             Clk,
  input  logic             R_N,
  jkff_bank_ctrl_if.slave  cmd,
  input  logic [WIDTH-1:0] FF_Q,
  output logic [WIDTH-1:0] FF_J,
  output logic [WIDTH-1:0] FF_K,
  output logic [WIDTH-1:0] FF_S,
  output logic [WIDTH-1:0] FF_R,
  output logic             Busy,
  output logic             Done,
  output logic             Err
);

  localparam int unsigned PCNT_W = 4;
  localparam logic [PCNT_W-1:0] PULSE_LOAD = PCNT_W'(PULSE_CYC);

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [WIDTH-1:0]  exp_q, exp_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic [WIDTH-1:0]  r_q, r_d;
  logic              mis_q, mis_d;

  logic [WIDTH-1:0]  j_raw;
  logic [WIDTH-1:0]  k_raw;

  jk_next_logic #(
    .WIDTH (WIDTH)
  ) u_next (
    .op   (op_q),
    .q    (FF_Q),
    .mask (data_q),
    .j    (j_raw),
    .k    (k_raw)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    rem_d   = rem_q;
    pcnt_d  = pcnt_q;
    exp_d   = exp_q;
    s_d     = s_q;
    r_d     = r_q;
    mis_d   = mis_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd.Cmd_Valid) begin
          op_d   = cmd.Cmd_Op;
          data_d = cmd.Cmd_Data;
          mis_d  = 1'b0;
          if (is_load_op(cmd.Cmd_Op)) begin
            pcnt_d  = PULSE_LOAD;
            state_d = ST_PULSE;
            case (cmd.Cmd_Op)
              OP_CLEAR: begin
                s_d   = '0;
                r_d   = '1;
                exp_d = '0;
              end
              OP_PRESET: begin
                s_d   = '1;
                r_d   = '0;
                exp_d = '1;
              end
              default: begin
                // LOAD: each bit is either set or cleared, never both.
                s_d   = cmd.Cmd_Data;
                r_d   = ~cmd.Cmd_Data;
                exp_d = cmd.Cmd_Data;
              end
            endcase
          end else if (is_counted_op(cmd.Cmd_Op)) begin
            rem_d   = cmd.Cmd_Cnt;
            state_d = (cmd.Cmd_Cnt == '0) ? ST_DONE : ST_RUN;
          end else if (cmd.Cmd_Op == OP_TOGGLE) begin
            rem_d   = CNT_W'(1);
            state_d = ST_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_PULSE: begin
        if (pcnt_q <= PCNT_W'(1)) begin
          s_d     = '0;
          r_d     = '0;
          state_d = ST_SETTLE;
        end else begin
          pcnt_d = pcnt_q - PCNT_W'(1);
        end
      end

      ST_SETTLE: begin
        mis_d   = (FF_Q != exp_q);
        state_d = ST_DONE;
      end

      ST_RUN: begin
        // Leaving on remaining == 1 gives exactly N edges with J/K driven.
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        s_d     = '0;
        r_d     = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge R_N) begin
    if (!R_N) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      data_q  <= '0;
      rem_q   <= '0;
      pcnt_q  <= '0;
      exp_q   <= '0;
      s_q     <= '0;
      r_q     <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      pcnt_q  <= pcnt_d;
      exp_q   <= exp_d;
      s_q     <= s_d;
      r_q     <= r_d;
      mis_q   <= mis_d;
    end
  end

  // Outputs
  always_comb begin
    cmd.Cmd_Ready = (state_q == ST_IDLE);
    Busy          = (state_q != ST_IDLE);
    Done          = (state_q == ST_DONE);
    Err           = (state_q == ST_DONE) & mis_q;
    FF_S          = s_q;
    // Clear the bank directly off the reset pin, independent of the clock.
    FF_R          = r_q | {WIDTH{~R_N}};
    FF_J          = (state_q == ST_RUN) ? j_raw : '0;
    FF_K          = (state_q == ST_RUN) ? k_raw : '0;
  end

endmodule

// File: tb/tb_jkff_bank_ctrl.sv
module tb_jkff_bank_ctrl;
  import jkff_ctrl_pkg::*;

  localparam int W  = 4;
  localparam int PC = 2;
  localparam int CW = 8;

  logic Clk = 1'b0;
  logic R_N = 1'b0;
  always #5 Clk = ~Clk;

  jkff_bank_ctrl_if #(.WIDTH(W), .CNT_W(CW)) cmd_if ();

  logic [W-1:0] FF_Q, FF_J, FF_K, FF_S, FF_R;
  logic         Busy, Done, Err;
  logic [W-1:0] bank_q = '0;
  logic [W-1:0] stuck0 = '0;

  int checks = 0;
  int errors = 0;
  int mq     = 0;

  jkff_bank_ctrl #(
    .WIDTH     (W),
    .PULSE_CYC (PC),
    .CNT_W     (CW)
  ) dut (
    .Clk  (Clk),
    .R_N  (R_N),
    .cmd  (cmd_if),
    .FF_Q (FF_Q),
    .FF_J (FF_J),
    .FF_K (FF_K),
    .FF_S (FF_S),
    .FF_R (FF_R),
    .Busy (Busy),
    .Done (Done),
    .Err  (Err)
  );

  // Behavioural 74HC112 bank; stuck0 forces observed Q bits to 0.
  always @(posedge Clk) begin
    for (int i = 0; i < W; i++) begin
      if (FF_R[i])                bank_q[i] <= 1'b0;
      else if (FF_S[i])           bank_q[i] <= 1'b1;
      else if (FF_J[i] && FF_K[i]) bank_q[i] <= ~bank_q[i];
      else if (FF_J[i])           bank_q[i] <= 1'b1;
      else if (FF_K[i])           bank_q[i] <= 1'b0;
    end
  end
  assign FF_Q = ((bank_q | FF_S) & ~FF_R) & ~stuck0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Invariants checked every cycle.
  always @(negedge Clk) begin
    if (R_N) begin
      check("s_and_r_exclusive", 32'(FF_S & FF_R), 32'd0);
      if (!Busy) begin
        check("idle_j", 32'(FF_J), 32'd0);
        check("idle_k", 32'(FF_K), 32'd0);
        check("idle_s", 32'(FF_S), 32'd0);
        check("idle_r", 32'(FF_R), 32'd0);
      end
    end else begin
      check("rst_ff_r", 32'(FF_R), 32'hF);
      check("rst_no_done", 32'(Done), 32'd0);
      check("rst_no_err", 32'(Err), 32'd0);
    end
  end

  function automatic int exp_latency(input int op, input int cnt);
    if (op >= 1 && op <= 3) return PC + 2;
    if (op == 6) return 2;
    if (op == 0 || cnt == 0) return 1;
    return cnt + 1;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge Clk);
    while (!cmd_if.Cmd_Ready && n < 100) begin
      @(negedge Clk);
      n++;
    end
    check("ready_wait", 32'(cmd_if.Cmd_Ready), 32'd1);
  endtask

  task automatic drive(input int op, input int data, input int cnt);
    cmd_if.Cmd_Valid = 1'b1;
    cmd_if.Cmd_Op    = 3'(op);
    cmd_if.Cmd_Data  = 4'(data);
    cmd_if.Cmd_Cnt   = 8'(cnt);
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!Done && lat < 300) begin
      @(posedge Clk);
      #1;
      lat++;
    end
  endtask

  // Issue one command and compare against the arithmetic model of the bank.
  task automatic run_cmd(input int op, input int data, input int cnt, input string tag);
    int lat;
    int tgt;
    logic exp_e;
    wait_ready();
    drive(op, data, cnt);
    @(posedge Clk);
    #1;
    cmd_if.Cmd_Valid = 1'b0;
    wait_done(lat);
    tgt   = 0;
    exp_e = 1'b0;
    case (op)
      1: begin mq = 0;  tgt = 0;    end
      2: begin mq = 15; tgt = 15;   end
      3: begin mq = data; tgt = data; end
      4: mq = (mq + cnt) & 15;
      5: mq = (mq - cnt) & 15;
      6: mq = mq ^ data;
      default: ;
    endcase
    if (op >= 1 && op <= 3) exp_e = ((tgt & ~int'(stuck0)) != tgt);
    check({tag, "_latency"}, 32'(lat), 32'(exp_latency(op, cnt)));
    check({tag, "_done"}, 32'(Done), 32'd1);
    check({tag, "_err"}, 32'(Err), 32'(exp_e));
    check({tag, "_q"}, 32'(FF_Q), 32'(mq & ~int'(stuck0)));
  endtask

  initial begin
    int lat;
    cmd_if.Cmd_Valid = 1'b0;
    cmd_if.Cmd_Op    = '0;
    cmd_if.Cmd_Data  = '0;
    cmd_if.Cmd_Cnt   = '0;

    // Power-on reset
    repeat (3) @(negedge Clk);
    check("por_ff_r", 32'(FF_R), 32'hF);
    R_N = 1'b1;
    @(posedge Clk);
    #1;
    check("por_ready", 32'(cmd_if.Cmd_Ready), 32'd1);
    check("por_busy", 32'(Busy), 32'd0);
    check("por_done", 32'(Done), 32'd0);
    check("por_q", 32'(FF_Q), 32'd0);

    // Reset in the middle of an UP run
    run_cmd(2, 0, 0, "preset0");
    wait_ready();
    drive(4, 0, 10);
    @(posedge Clk);
    #1;
    cmd_if.Cmd_Valid = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    R_N = 1'b0;
    #1;
    check("midrst_ff_r", 32'(FF_R), 32'hF);
    check("midrst_q", 32'(FF_Q), 32'd0);
    check("midrst_done", 32'(Done), 32'd0);
    check("midrst_busy", 32'(Busy), 32'd0);
    repeat (2) @(negedge Clk);
    R_N = 1'b1;
    mq  = 0;
    @(posedge Clk);
    #1;
    check("rel_ready", 32'(cmd_if.Cmd_Ready), 32'd1);
    check("rel_outs", 32'({FF_J, FF_K, FF_S, FF_R, Busy, Done, Err}), 32'd0);
    check("rel_q", 32'(FF_Q), 32'd0);

    // LOAD 0xA with cycle-by-cycle pulse checks
    wait_ready();
    drive(3, 4'hA, 0);
    @(posedge Clk);
    #1;
    cmd_if.Cmd_Valid = 1'b0;
    check("load_c1_s", 32'(FF_S), 32'hA);
    check("load_c1_r", 32'(FF_R), 32'h5);
    @(posedge Clk);
    #1;
    check("load_c2_s", 32'(FF_S), 32'hA);
    check("load_c2_r", 32'(FF_R), 32'h5);
    @(posedge Clk);
    #1;
    check("load_c3_sr", 32'({FF_S, FF_R}), 32'd0);
    check("load_c3_done", 32'(Done), 32'd0);
    @(posedge Clk);
    #1;
    check("load_c4_done", 32'(Done), 32'd1);
    check("load_c4_err", 32'(Err), 32'd0);
    check("load_c4_q", 32'(FF_Q), 32'hA);
    mq = 4'hA;

    // Stuck-at-0 on bit 1 must raise Err
    stuck0 = 4'b0010;
    run_cmd(3, 4'hA, 0, "load_stuck");
    @(posedge Clk);
    #1;
    check("stuck_err_pulse", 32'(Err), 32'd0);
    stuck0 = 4'b0000;

    // Counting with wrap, preset/down, toggle
    run_cmd(1, 0, 0, "clear");
    run_cmd(4, 0, 18, "up18");
    check("up18_value", 32'(FF_Q), 32'h2);
    run_cmd(2, 0, 0, "preset");
    run_cmd(5, 0, 3, "down3");
    check("down3_value", 32'(FF_Q), 32'hC);
    run_cmd(6, 4'h9, 0, "toggle9");
    check("toggle9_value", 32'(FF_Q), 32'h5);
    run_cmd(7, 0, 0, "hold0");
    run_cmd(0, 4'hF, 5, "nop");

    // Cmd_Valid held high while busy: the second command waits for Ready
    wait_ready();
    drive(7, 0, 4);
    @(posedge Clk);
    #1;
    drive(6, 4'hF, 0);
    lat = 1;
    while (!Done && lat < 50) begin
      check("held_ready_low", 32'(cmd_if.Cmd_Ready), 32'd0);
      @(posedge Clk);
      #1;
      lat++;
    end
    check("held_hold_latency", 32'(lat), 32'd5);
    check("held_hold_q", 32'(FF_Q), 32'(mq));
    @(posedge Clk);
    #1;
    check("held_idle_ready", 32'(cmd_if.Cmd_Ready), 32'd1);
    @(posedge Clk);
    #1;
    cmd_if.Cmd_Valid = 1'b0;
    check("held_second_busy", 32'(Busy), 32'd1);
    wait_done(lat);
    mq = mq ^ 15;
    check("held_toggle_latency", 32'(lat), 32'd2);
    check("held_toggle_q", 32'(FF_Q), 32'(mq));

    // Randomized commands against the model
    for (int n = 0; n < 30; n++) begin
      run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 20)), "rand");
    end

    repeat (2) @(posedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jkff_bank_ctrl.md
Name: jkff_bank_ctrl

Overview:
Command-driven sequencer for a bank of WIDTH JK flip-flops of the 74HC112 type. Each flip-flop has J, K, async set S, async clear R (both active-high at the flip-flop), Q and Q_N.
- Accepts one command at a time over a valid/ready handshake.
- Drives set/clear pulses or per-bit J/K for a programmed number of clocks.
- Checks the bank's Q feedback after every load-type operation.
- Sits between the lab top-level command source and the flip-flop bank; the bank shares Clk.

Parameters:
- WIDTH, 4: number of JK flip-flops in the bank.
- PULSE_CYC, 2: cycles S/R pulses are held (1..15).
- CNT_W, 8: width of the run-length field.

Ports:
- Clk  in  1  rising-edge clock; the bank is clocked by the same net.
- R_N  in  1  asynchronous active-low reset.
- Cmd_Valid  in  1  command present.
- Cmd_Ready  out  1  controller can accept a command.
- Cmd_Op  in  3  opcode.
- Cmd_Data  in  WIDTH  load value or toggle mask.
- Cmd_Cnt  in  CNT_W  run length in clocks.
- FF_Q  in  WIDTH  Q outputs of the bank.
- FF_J  out  WIDTH  J inputs of the bank.
- FF_K  out  WIDTH  K inputs of the bank.
- FF_S  out  WIDTH  async set to the bank, active-high.
- FF_R  out  WIDTH  async clear to the bank, active-high.
- Busy  out  1  high when not IDLE.
- Done  out  1  one-cycle completion pulse.
- Err  out  1  one-cycle pulse coincident with Done on verify mismatch.

Behaviour:
- Reset (R_N low, async):
  - state = IDLE; counters = 0.
  - FF_J = FF_K = FF_S = 0.
  - FF_R = all ones, forced combinationally while R_N is low, so the bank clears.
  - Done = Err = Busy = 0; Cmd_Ready = 1 after release.
- Reset mid-operation aborts the command; no Done and no Err are produced.
- Opcodes:
  - 0 NOP: no effect; Done the next cycle.
  - 1 CLEAR: FF_R = all ones; expected Q = 0.
  - 2 PRESET: FF_S = all ones; expected Q = all ones.
  - 3 LOAD: FF_S = Cmd_Data and FF_R = ~Cmd_Data; expected Q = Cmd_Data.
  - 4 UP: synchronous binary up-count for Cmd_Cnt clocks. J_i = K_i = AND(FF_Q[i-1:0]); bit 0 is always 1.
  - 5 DOWN: J_i = K_i = AND(~FF_Q[i-1:0]); bit 0 is always 1.
  - 6 TOGGLE: J = K = Cmd_Data for exactly one clock.
  - 7 HOLD: J = K = 0 for Cmd_Cnt clocks.
- Handshake:
  - Cmd_Ready = 1 only in IDLE.
  - Accept on Cmd_Valid & Cmd_Ready at a rising edge; Cmd_Op, Cmd_Data and Cmd_Cnt are captured into registers.
  - Cmd_Valid outside IDLE is ignored and the inputs are not sampled.
- States: IDLE, PULSE, SETTLE, RUN, DONE.
  - IDLE → PULSE for ops 1-3.
  - IDLE → RUN for ops 4-7. TOGGLE uses a run length of 1.
  - IDLE → DONE for NOP, or for ops 4/5/7 with Cmd_Cnt = 0.
  - PULSE: registered FF_S/FF_R held for PULSE_CYC cycles with J = K = 0, then → SETTLE.
  - SETTLE: one cycle with S = R = 0, J = K = 0. At the end of the cycle, FF_Q is compared against the expected value and the mismatch flag is registered; then → DONE.
  - RUN: J/K are combinational from FF_Q and the opcode. The remaining count loads the run length and decrements on every edge in RUN; RUN is left when remaining = 1, so exactly N bank clocks see the J/K values. Then → DONE.
  - DONE: Done = 1; Err = mismatch flag, which is only ever set by ops 1-3. J = K = S = R = 0. → IDLE.
- Latency, counted from the accept edge:
  - Ops 1-3: Done in cycle PULSE_CYC+2, i.e. 4 with the default.
  - Ops 4/5/7 with N ≥ 1: Done in cycle N+1.
  - TOGGLE: Done in cycle 2.
  - NOP or N = 0: Done in cycle 1.
- Invariants:
  - FF_S & FF_R == 0 at all times.
  - FF_J/FF_K are zero outside RUN.
  - FF_S/FF_R are zero outside PULSE, except the reset override of FF_R.
- Count wrap-around: UP from all ones → 0; DOWN from 0 → all ones. This is inherent in the J/K equations; no flag is raised.
- Err is not evaluated in RUN.

Decomposition:
- Package jkff_ctrl_pkg holds:
  - opcode localparams OP_NOP..OP_HOLD;
  - state encoding ST_IDLE..ST_DONE;
  - default CNT_W.
- Sub-module jk_next_logic (combinational). Inputs: opcode, FF_Q, mask. Outputs: FF_J, FF_K. It holds the prefix-AND up/down equations and the toggle mask, and is reusable for wider counter labs.
- Top level contains the FSM, the pulse/run counters and the verify compare.

Test Plan (WIDTH = 4, PULSE_CYC = 2, behavioural 74HC112 model as the bank):
- Reset asserted mid-UP run → FF_R = 4'hF immediately, Q = 0, no Done; after release Cmd_Ready = 1 and all other outputs are 0.
- LOAD Data = 4'hA → FF_S = 4'hA and FF_R = 4'h5 for 2 cycles; Done in cycle 4; Q = 4'hA; Err = 0.
- LOAD 4'hA with bank bit 1 forced stuck at 0 → Done with Err = 1.
- After CLEAR, UP Cnt = 18 → exactly 18 bank clocks; Q = 4'h2 (wrap through 4'hF → 0); Done in cycle 19.
- PRESET, then DOWN Cnt = 3 → Q = 4'hC. Then TOGGLE Data = 4'h9 → Q = 4'h5.
- HOLD Cnt = 0 and NOP → Done in cycle 1 with Q unchanged. Cmd_Valid held high during Busy → no second command accepted until Cmd_Ready.
